// File: rtl/ram_line_responder.sv
// Memory-side responder for the cache RAM line interface: DEPTH-line store with
// fixed beat timing and a generated fill pattern for lines not written since reset.
module ram_line_responder #(
   parameter int ADDR_SIZE = 13,
   parameter int WORD_SIZE = 16,
   parameter int LINE_WIDTH = 64,
   parameter int RD_LATENCY = 4,
   parameter logic [WORD_SIZE-1:0] FILL_TAG = 16'hC0DE
) (
   input  logic                  ram_clk,
   input  logic                  ram_rst,
   input  logic [ADDR_SIZE-1:0]  ram_addr,
   input  logic                  ram_avalid,
   input  logic                  ram_rnw,
   input  logic [WORD_SIZE-1:0]  ram_wdata,
   output logic [WORD_SIZE-1:0]  ram_rdata,
   output logic                  ram_ack,
   output logic                  ram_busy,
   output logic                  protocol_err,
   output logic [LINE_WIDTH-1:0] dbg_line
);

   localparam int DEPTH = 2 ** ADDR_SIZE;
   localparam int BEATS = LINE_WIDTH / WORD_SIZE;
   localparam int BW = $clog2(BEATS);
   localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic [2:0] {INIT, IDLE, WR_BEATS, WR_ACK, RD_WAIT, RD_BEATS} state_t;

   state_t                state_q, state_d;
   logic [ADDR_SIZE-1:0]  initCnt_q, initCnt_d;
   logic [BW-1:0]         beatCnt_q, beatCnt_d;
   logic [LW-1:0]         latCnt_q, latCnt_d;
   logic [ADDR_SIZE-1:0]  addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wrLine_q, wrLine_d;
   logic [LINE_WIDTH-1:0] dbgLine_q, dbgLine_d;
   logic                  hit_q, hit_d;
   logic                  err_q, err_d;

   logic [LINE_WIDTH-1:0] mem [DEPTH];
   logic [LINE_WIDTH-1:0] memRd_q;
   logic [DEPTH-1:0]      valid_q;
   logic [LINE_WIDTH-1:0] fillLine;
   logic [LINE_WIDTH-1:0] rdLine;
   logic                  commit;

   assign commit = (state_q == WR_ACK) && !ram_rst;

   // Even beats carry the line address, odd beats the fill tag.
   always_comb begin
      fillLine = '0;
      for (int i = 0; i < BEATS; i++) begin
         fillLine[i*WORD_SIZE +: WORD_SIZE] = (i % 2 == 0) ? WORD_SIZE'(addr_q) : FILL_TAG;
      end
   end

   assign rdLine = hit_q ? memRd_q : fillLine;

   always_comb begin
      state_d   = state_q;
      initCnt_d = initCnt_q;
      beatCnt_d = beatCnt_q;
      latCnt_d  = latCnt_q;
      addr_d    = addr_q;
      wrLine_d  = wrLine_q;
      dbgLine_d = dbgLine_q;
      hit_d     = hit_q;
      err_d     = err_q | (ram_avalid && (state_q != IDLE));
      case (state_q)
         INIT: begin
            initCnt_d = initCnt_q + 1'b1;
            if (initCnt_q == '1) state_d = IDLE;
         end
         IDLE: begin
            if (ram_avalid) begin
               addr_d = ram_addr;
               beatCnt_d = '0;
               if (ram_rnw) begin
                  hit_d = valid_q[ram_addr];
                  latCnt_d = LW'(1);
                  state_d = (RD_LATENCY == 1) ? RD_BEATS : RD_WAIT;
               end else begin
                  wrLine_d[WORD_SIZE-1:0] = ram_wdata;
                  beatCnt_d = BW'(1);
                  state_d = WR_BEATS;
               end
            end
         end
         WR_BEATS: begin
            wrLine_d[int'(beatCnt_q)*WORD_SIZE +: WORD_SIZE] = ram_wdata;
            if (beatCnt_q == BW'(BEATS-1)) begin
               beatCnt_d = '0;
               state_d = WR_ACK;
            end else begin
               beatCnt_d = beatCnt_q + 1'b1;
            end
         end
         WR_ACK: begin
            dbgLine_d = wrLine_q;
            state_d = IDLE;
         end
         RD_WAIT: begin
            latCnt_d = latCnt_q + 1'b1;
            if (latCnt_q == LW'(RD_LATENCY-1)) state_d = RD_BEATS;
         end
         RD_BEATS: begin
            if (beatCnt_q == BW'(BEATS-1)) begin
               beatCnt_d = '0;
               state_d = IDLE;
            end else begin
               beatCnt_d = beatCnt_q + 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge ram_clk) begin
      if (ram_rst) begin
         state_q   <= INIT;
         initCnt_q <= '0;
         beatCnt_q <= '0;
         latCnt_q  <= '0;
         addr_q    <= '0;
         wrLine_q  <= '0;
         dbgLine_q <= '0;
         hit_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         initCnt_q <= initCnt_d;
         beatCnt_q <= beatCnt_d;
         latCnt_q  <= latCnt_d;
         addr_q    <= addr_d;
         wrLine_q  <= wrLine_d;
         dbgLine_q <= dbgLine_d;
         hit_q     <= hit_d;
         err_q     <= err_d;
      end
   end

   // Line array has no reset so it maps onto block RAM; the read is registered at request time.
   always_ff @(posedge ram_clk) begin
      if (commit) mem[addr_q] <= wrLine_q;
      if ((state_q == IDLE) && ram_avalid && ram_rnw) memRd_q <= mem[ram_addr];
   end

   always_ff @(posedge ram_clk) begin
      if (state_q == INIT) valid_q[initCnt_q] <= 1'b0;
      else if (commit) valid_q[addr_q] <= 1'b1;
   end

   always_comb begin
      ram_rdata = '0;
      if (state_q == RD_BEATS) ram_rdata = rdLine[int'(beatCnt_q)*WORD_SIZE +: WORD_SIZE];
   end

   assign ram_ack      = (state_q == WR_ACK) || (state_q == RD_BEATS);
   assign ram_busy     = (state_q != IDLE);
   assign protocol_err = err_q;
   assign dbg_line     = dbgLine_q;

endmodule

// File: tb/tb_ram_line_responder.sv
// Scoreboard bench for ram_line_responder: default instance plus a small RD_LATENCY=1 instance.
module tb_ram_line_responder;

   localparam int DEPTH = 8192;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0, avalid = 1'b0, rnw = 1'b0;
   logic [12:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata;
   logic        ack, busy, perr;
   logic [63:0] dbg;

   logic        rst2 = 1'b1, avalid2 = 1'b0, rnw2 = 1'b0;
   logic [3:0]  addr2 = '0;
   logic [15:0] wdata2 = '0;
   logic [15:0] rdata2;
   logic        ack2, busy2, perr2;
   logic [63:0] dbg2;

   ram_line_responder dut (
      .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_avalid(avalid), .ram_rnw(rnw),
      .ram_wdata(wdata), .ram_rdata(rdata), .ram_ack(ack), .ram_busy(busy),
      .protocol_err(perr), .dbg_line(dbg)
   );

   ram_line_responder #(.ADDR_SIZE(4), .RD_LATENCY(1)) dutLat1 (
      .ram_clk(clk), .ram_rst(rst2), .ram_addr(addr2), .ram_avalid(avalid2), .ram_rnw(rnw2),
      .ram_wdata(wdata2), .ram_rdata(rdata2), .ram_ack(ack2), .ram_busy(busy2),
      .protocol_err(perr2), .dbg_line(dbg2)
   );

   typedef struct {
      int          cycle;
      logic [15:0] data;
   } exp_t;

   exp_t sb1[$];
   exp_t sb2[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitors pop one expected beat per acked cycle and compare cycle and data.
   always @(negedge clk) begin
      exp_t e;
      if (ack === 1'b1) begin
         if (sb1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected ack: got ack at cycle %0d, expected none", cyc);
         end else begin
            e = sb1.pop_front();
            checkOutput("ack cycle", 64'(cyc), 64'(e.cycle));
            checkOutput("ack rdata", 64'(rdata), 64'(e.data));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (ack2 === 1'b1) begin
         if (sb2.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected ack lat1: got ack at cycle %0d, expected none", cyc);
         end else begin
            e = sb2.pop_front();
            checkOutput("lat1 ack cycle", 64'(cyc), 64'(e.cycle));
            checkOutput("lat1 ack rdata", 64'(rdata2), 64'(e.data));
         end
      end
   end

   task automatic waitIdle(output int idleCyc);
      int n = 0;
      while (busy !== 1'b0 && n < DEPTH + 100) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         checks++;
         errors++;
         $display("[TB] FAIL idle timeout: got busy=%b, expected 0", busy);
      end
      idleCyc = cyc;
   endtask

   task automatic applyReset(input logic pulseInit);
      int r, ic;
      @(negedge clk);
      rst = 1'b1;
      avalid = 1'b0;
      r = cyc;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset busy", 64'(busy), 64'd1);
      checkOutput("reset ack", 64'(ack), 64'd0);
      checkOutput("reset rdata", 64'(rdata), 64'd0);
      checkOutput("reset perr", 64'(perr), 64'd0);
      checkOutput("reset dbg_line", dbg, 64'd0);
      if (pulseInit) begin
         @(negedge clk);
         avalid = 1'b1;
         rnw = 1'b1;
         addr = 13'h0005;
         @(negedge clk);
         avalid = 1'b0;
         checkOutput("perr after init pulse", 64'(perr), 64'd1);
      end
      waitIdle(ic);
      checkOutput("init length", 64'(ic), 64'(r + DEPTH + 1));
   endtask

   task automatic applyRead(input logic [12:0] a, input logic [63:0] line, input logic pulseMid);
      int c, ic;
      @(negedge clk);
      addr = a;
      rnw = 1'b1;
      avalid = 1'b1;
      c = cyc;
      for (int i = 0; i < 4; i++) sb1.push_back('{c + 4 + i, line[i*16 +: 16]});
      @(negedge clk);
      avalid = 1'b0;
      addr = '0;
      if (pulseMid) begin
         @(negedge clk);
         avalid = 1'b1;
         rnw = 1'b0;
         addr = 13'h0042;
         wdata = 16'h5555;
         @(negedge clk);
         avalid = 1'b0;
         wdata = '0;
      end
      waitIdle(ic);
      checkOutput("read busy fall", 64'(ic), 64'(c + 8));
   endtask

   task automatic applyWrite(input logic [12:0] a, input logic [63:0] line);
      int c, ic;
      @(negedge clk);
      addr = a;
      rnw = 1'b0;
      avalid = 1'b1;
      wdata = line[15:0];
      c = cyc;
      sb1.push_back('{c + 4, 16'h0000});
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         avalid = 1'b0;
         wdata = line[i*16 +: 16];
      end
      @(negedge clk);
      wdata = '0;
      waitIdle(ic);
      checkOutput("write busy fall", 64'(ic), 64'(c + 5));
      checkOutput("dbg_line", dbg, line);
   endtask

   initial begin
      int c, r, ic, n;
      @(negedge clk);
      @(negedge clk);
      rst2 = 1'b0;

      applyReset(1'b1);
      checkOutput("perr sticky after init", 64'(perr), 64'd1);

      applyRead(13'h1579, 64'hC0DE1579C0DE1579, 1'b0);
      applyWrite(13'h1779, 64'hDEADBEEF10009BBC);
      applyRead(13'h1779, 64'hDEADBEEF10009BBC, 1'b0);
      applyWrite(13'h1779, 64'hDEADBEEFDEADF00D);
      applyRead(13'h177A, 64'hC0DE177AC0DE177A, 1'b0);
      applyRead(13'h1779, 64'hDEADBEEFDEADF00D, 1'b1);
      checkOutput("perr still set", 64'(perr), 64'd1);
      checkOutput("dbg unchanged by ignored write", dbg, 64'hDEADBEEFDEADF00D);

      // Reset lands on the second read beat; only two beats may be acked.
      @(negedge clk);
      addr = 13'h1779;
      rnw = 1'b1;
      avalid = 1'b1;
      c = cyc;
      sb1.push_back('{c + 4, 16'hF00D});
      sb1.push_back('{c + 5, 16'hDEAD});
      @(negedge clk);
      avalid = 1'b0;
      n = 0;
      while (cyc < c + 5 && n < 20) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      r = cyc;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mid reset ack", 64'(ack), 64'd0);
      checkOutput("mid reset rdata", 64'(rdata), 64'd0);
      checkOutput("mid reset busy", 64'(busy), 64'd1);
      checkOutput("mid reset perr", 64'(perr), 64'd0);
      waitIdle(ic);
      checkOutput("mid reset init length", 64'(ic), 64'(r + DEPTH + 1));
      applyRead(13'h1779, 64'hC0DE1779C0DE1779, 1'b0);

      @(negedge clk);
      checkOutput("lat1 idle", 64'(busy2), 64'd0);
      addr2 = 4'h0;
      rnw2 = 1'b1;
      avalid2 = 1'b1;
      c = cyc;
      sb2.push_back('{c + 1, 16'h0000});
      sb2.push_back('{c + 2, 16'hC0DE});
      sb2.push_back('{c + 3, 16'h0000});
      sb2.push_back('{c + 4, 16'hC0DE});
      @(negedge clk);
      avalid2 = 1'b0;
      n = 0;
      while (busy2 !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("lat1 busy fall", 64'(cyc), 64'(c + 5));
      checkOutput("lat1 perr", 64'(perr2), 64'd0);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", 64'(sb1.size()), 64'd0);
      checkOutput("lat1 scoreboard drained", 64'(sb2.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global timeout: got no completion, expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/ram_line_responder.md
Name: ram_line_responder

Overview:
- Synthesizable memory-side responder for the cache's RAM line interface.
- The cache is the initiator: it issues line-address requests and streams write lines or collects read lines as WORD_SIZE beats.
- This block holds a DEPTH-line store, answers each request with the agreed beat timing, and returns a generated fill pattern for lines never written since reset.
- It replaces the behavioural RAM stub in system builds and acts as the RAM model in cache benches.

Parameters:
- ADDR_SIZE, 13, line-address width; DEPTH = 2**ADDR_SIZE lines.
- WORD_SIZE, 16, beat width on ram_wdata/ram_rdata.
- LINE_WIDTH, 64, line width; BEATS = LINE_WIDTH/WORD_SIZE (default 4; must be an integer ≥ 2).
- RD_LATENCY, 4, cycles from request cycle to first read beat; legal range ≥ 1.
- FILL_TAG, 16'hC0DE, constant used in the fill pattern; width = WORD_SIZE.

Ports:
- ram_clk  in  1  sole clock; all logic on rising edge.
- ram_rst  in  1  synchronous, active-high reset.
- ram_addr  in  ADDR_SIZE  line address; sampled only in the request cycle.
- ram_avalid  in  1  request strobe; one-cycle pulse.
- ram_rnw  in  1  1 = read line, 0 = write line; sampled with ram_avalid.
- ram_wdata  in  WORD_SIZE  write beats; beat 0 arrives in the request cycle.
- ram_rdata  out  WORD_SIZE  read beat; valid while ram_ack=1 during a read.
- ram_ack  out  1  read: high on each data beat; write: one-cycle completion pulse.
- ram_busy  out  1  high while initialising or serving a request.
- protocol_err  out  1  sticky error flag; cleared only by reset.
- dbg_line  out  LINE_WIDTH  last line committed by a write (backdoor for benches).

Behaviour:
- Reset, sampled at a rising edge:
  - Next state is INIT.
  - ram_ack=0, ram_rdata=0, protocol_err=0, dbg_line=0, ram_busy=1.
  - Beat and latency counters are cleared.
  - Reset mid-operation aborts the transfer in progress: no further acks, and any partial write line is discarded.
- FSM states are INIT, IDLE, WR_BEATS, WR_ACK, RD_WAIT, RD_BEATS.
- INIT:
  - Sweeps a counter over 0..DEPTH-1, clearing one per-line valid bit per cycle; array data is not cleared.
  - Lasts exactly DEPTH cycles, then moves to IDLE; ram_busy=0 only in IDLE.
- IDLE:
  - With ram_avalid=1, latch ram_addr and ram_rnw.
  - Write: capture beat 0 into the line buffer at bits [WORD_SIZE-1:0], then go to WR_BEATS.
  - Read: go to RD_WAIT.
- WR_BEATS:
  - Captures beats 1..BEATS-1 on consecutive cycles (low beat first); the initiator does not stall.
  - After the last beat, go to WR_ACK.
- WR_ACK:
  - Commits the line to the array, sets the line's valid bit, and loads dbg_line.
  - ram_ack=1 for this single cycle, then return to IDLE.
  - Timing: request at cycle 0 gives ack at cycle BEATS (cycle 4 by default).
- RD_WAIT: counts RD_LATENCY-1 cycles.
- RD_BEATS:
  - ram_ack=1 with beat i on ram_rdata for BEATS consecutive cycles, RD_LATENCY..RD_LATENCY+BEATS-1, low beat first.
  - After the last beat: ram_ack=0, ram_rdata=0, return to IDLE.
  - Outside read beats ram_rdata=0.
- Fill pattern for a line whose valid bit is clear:
  - Every even beat = ram_addr zero-extended to WORD_SIZE.
  - Every odd beat = FILL_TAG.
  - Default for line 0x1579: 64'hC0DE1579C0DE1579.
- Partial writes do not exist: every write replaces the whole line.
- Protocol errors: ram_avalid=1 in any state other than IDLE, including INIT, is ignored and sets protocol_err. The current transfer is unaffected.
- Back-to-back requests: a new request is accepted on the first IDLE cycle, i.e. the cycle after WR_ACK or after the last read beat.
- Address wrap: none needed; ram_addr is exactly ADDR_SIZE bits and always in range.

Test Plan:
- Read of an unwritten line:
  - Stimulus: reset; wait DEPTH cycles until ram_busy=0; read addr 0x1579.
  - Required: ram_ack high on cycles 4..7 with beats 0x1579, 0xC0DE, 0x1579, 0xC0DE; ram_busy falls at cycle 8.
- Write then read back:
  - Stimulus: write addr 0x1779 with beats 0x9BBC, 0x1000, 0xBEEF, 0xDEAD.
  - Required: single ram_ack at cycle 4; dbg_line = 64'hDEADBEEF10009BBC. A following read of 0x1779 returns the same four beats at cycles 4..7.
- Overwrite and neighbour:
  - Stimulus: rewrite 0x1779 with 0xF00D, 0xDEAD, 0xBEEF, 0xDEAD; then read 0x177A.
  - Required: dbg_line = 64'hDEADBEEFDEADF00D; 0x177A returns the fill pattern, proving no aliasing.
- Request while busy:
  - Stimulus: pulse ram_avalid during INIT, and again on cycle 2 of a read.
  - Required: both pulses ignored; protocol_err=1 and stays set; the read still completes 4 correct beats.
- Reset mid-transfer:
  - Stimulus: assert ram_rst on the second read beat of line 0x1779.
  - Required: ram_ack=0 and ram_rdata=0 from the next cycle; ram_busy=1 for DEPTH cycles. After init, reading 0x1779 returns the fill pattern 64'hC0DE1779C0DE1779 because valid bits were cleared.
- Latency parameter:
  - Stimulus: RD_LATENCY=1; read 0x0000 after init.
  - Required: beats 0x0000, 0xC0DE, 0x0000, 0xC0DE on cycles 1..4.
